// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared op and state encodings for the RV32M multiply/divide sequencer
package muldiv_sequencer_pkg;
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_t;
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL_ST = 2'd1,
    MD_DIV_ST = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: execute-stage handshake between the decode path and the mul/div sequencer
interface muldiv_sequencer_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            kill;
  logic            busy;
  logic            out_valid;
  logic [XLEN-1:0] result;
  modport master (output in_valid, funct3, op_a, op_b, kill,
                  input  in_ready, busy, out_valid, result);
  modport slave  (input  in_valid, funct3, op_a, op_b, kill,
                  output in_ready, busy, out_valid, result);
endinterface

// File: rtl/muldiv_sign_prep.sv
// muldiv_sign_prep: operand magnitudes and result-negate flag for an M-extension op
module muldiv_sign_prep
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            neg
);
  logic a_signed, b_signed, sa, sb;
  always_comb begin
    a_signed = funct3 == MD_MUL || funct3 == MD_MULH || funct3 == MD_MULHSU ||
               funct3 == MD_DIV || funct3 == MD_REM;
    b_signed = funct3 == MD_MUL || funct3 == MD_MULH || funct3 == MD_DIV || funct3 == MD_REM;
    sa = a_signed && op_a[XLEN-1];
    sb = b_signed && op_b[XLEN-1];
    mag_a = sa ? -op_a : op_a;
    mag_b = sb ? -op_b : op_b;
    neg = funct3 == MD_REM ? sa : sa ^ sb;
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M controller; shift-add multiply or restoring divide over XLEN cycles
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input logic clk,
  input logic reset,
  muldiv_sequencer_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'(MD_IDLE);
  localparam logic [1:0] S_MUL  = 2'(MD_MUL_ST);
  localparam logic [1:0] S_DIV  = 2'(MD_DIV_ST);
  localparam logic [1:0] S_DONE = 2'(MD_DONE);
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d, rem_q, rem_d, result_q, result_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              neg_in;
  logic              accept, last, iter, ge;
  logic [XLEN:0]     sum, shifted;
  logic [2*XLEN-1:0] prod_next, prod_neg;
  logic [XLEN-1:0]   rem_next, quo_next, div_val;
  muldiv_sign_prep #(.XLEN(XLEN)) u_prep (
    .funct3(bus.funct3),
    .op_a(bus.op_a),
    .op_b(bus.op_b),
    .mag_a(mag_a),
    .mag_b(mag_b),
    .neg(neg_in)
  );
  // acc holds the product (MUL) or dividend/quotient in its low half (DIV)
  always_comb begin
    accept = bus.in_valid && state_q == S_IDLE && !bus.kill;
    last = cnt_q == CNT_W'(XLEN - 1);
    iter = state_q == S_MUL || state_q == S_DIV;
    sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    prod_next = {sum, acc_q[XLEN-1:1]};
    prod_neg = neg_q ? -prod_next : prod_next;
    shifted = {rem_q, acc_q[XLEN-1]};
    ge = shifted >= {1'b0, opnd_q};
    rem_next = ge ? XLEN'(shifted - {1'b0, opnd_q}) : shifted[XLEN-1:0];
    quo_next = {acc_q[XLEN-2:0], ge};
    div_val = f3_q[1] ? rem_next : quo_next;
    state_d = bus.kill ? S_IDLE
            : accept ? (!bus.funct3[2] ? S_MUL : (|bus.op_b ? S_DIV : S_DONE))
            : state_q == S_DONE ? S_IDLE
            : iter && last ? S_DONE : state_q;
    cnt_d = iter && !last && !bus.kill ? cnt_q + 1'b1 : '0;
    acc_d = accept ? {{XLEN{1'b0}}, bus.funct3[2] ? mag_a : mag_b}
          : state_q == S_MUL ? prod_next
          : state_q == S_DIV ? {acc_q[2*XLEN-1:XLEN], quo_next} : acc_q;
    opnd_d = accept ? (bus.funct3[2] ? mag_b : mag_a) : opnd_q;
    rem_d = accept ? '0 : state_q == S_DIV ? rem_next : rem_q;
    f3_d = accept ? bus.funct3 : f3_q;
    neg_d = accept ? neg_in : neg_q;
    result_d = bus.kill ? result_q
             : accept && bus.funct3[2] && bus.op_b == '0 ? (bus.funct3[1] ? bus.op_a : '1)
             : state_q == S_MUL && last ? (f3_q == MD_MUL ? prod_neg[XLEN-1:0] : prod_neg[2*XLEN-1:XLEN])
             : state_q == S_DIV && last ? (neg_q ? -div_val : div_val) : result_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      rem_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      rem_q    <= rem_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end
  assign bus.in_ready  = state_q == S_IDLE;
  assign bus.busy      = state_q != S_IDLE;
  assign bus.out_valid = state_q == S_DONE && !bus.kill;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized checks of the mul/div sequencer against a 64-bit arithmetic model
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  logic [31:0] last_exp;
  muldiv_sequencer_if #(.XLEN(32)) bus();
  muldiv_sequencer #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: p = sa * sb;
      3'd1: p = (sa * sb) >>> 32;
      3'd2: p = (sa * ub) >>> 32;
      3'd3: p = (ua * ub) >> 32;
      3'd4: p = (b == 0) ? -1 : sa / sb;
      3'd5: p = (b == 0) ? -1 : ua / ub;
      3'd6: p = (b == 0) ? sa : sa % sb;
      default: p = (b == 0) ? ua : ua % ub;
    endcase
    return p[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string tag, input bit hold);
    int lat;
    int extra;
    @(negedge clk);
    chk({tag, " in_ready_before"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.funct3 = f;
    bus.op_a = a;
    bus.op_b = b;
    @(negedge clk);
    bus.in_valid = hold;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    chk({tag, " latency"}, 32'(lat), (f[2] && b == 0) ? 32'd1 : 32'd33);
    chk({tag, " result"}, bus.result, exp);
    last_exp = exp;
    extra = 0;
    repeat (hold ? 5 : 1) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) extra++;
    end
    chk({tag, " idle_after"}, 32'(extra), 32'd0);
    chk({tag, " in_ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [2:0] f;
    logic [31:0] a, b;
    int ov;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.kill = 1'b0;
    bus.funct3 = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    last_exp = '0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst result", bus.result, 32'd0);
    reset = 1'b0;
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul_7x-3", 0);
    do_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min", 0);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max", 0);
    do_op(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, "mulhsu", 0);
    do_op(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_-7_2", 0);
    do_op(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_-7_2", 0);
    do_op(3'd5, 32'd100, 32'd7, 32'd14, "divu_100_7", 0);
    do_op(3'd7, 32'd100, 32'd7, 32'd2, "remu_100_7", 0);
    do_op(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_by0", 0);
    do_op(3'd6, 32'd5, 32'd0, 32'd5, "rem_by0", 0);
    do_op(3'd4, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, "div_neg_by0", 0);
    do_op(3'd6, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, "rem_neg_by0", 0);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf", 0);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem_ovf", 0);
    do_op(3'd4, 32'd1000, 32'hFFFFFFF6, 32'hFFFFFF9C, "div_hold", 1);
    // kill mid-multiply: accepted in cycle 0, kill in cycle 10
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.funct3 = 3'd0;
    bus.op_a = 32'd12345;
    bus.op_b = 32'd678;
    ov = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) begin
      if (bus.out_valid !== 1'b0) ov++;
      @(negedge clk);
    end
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    chk("kill busy", 32'(bus.busy), 32'd0);
    chk("kill in_ready", 32'(bus.in_ready), 32'd1);
    chk("kill result_kept", bus.result, last_exp);
    repeat (40) begin
      if (bus.out_valid !== 1'b0) ov++;
      @(negedge clk);
    end
    chk("kill no_out_valid", 32'(ov), 32'd0);
    // reset mid-multiply
    bus.in_valid = 1'b1;
    bus.op_a = 32'd99;
    bus.op_b = 32'd77;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid busy", 32'(bus.busy), 32'd0);
    chk("rstmid in_ready", 32'(bus.in_ready), 32'd1);
    chk("rstmid result", bus.result, 32'd0);
    last_exp = '0;
    // kill together with in_valid while idle
    bus.in_valid = 1'b1;
    bus.kill = 1'b1;
    bus.funct3 = 3'd5;
    bus.op_b = 32'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.kill = 1'b0;
    chk("kill_idle busy", 32'(bus.busy), 32'd0);
    chk("kill_idle out_valid", 32'(bus.out_valid), 32'd0);
    chk("kill_idle result", bus.result, 32'd0);
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      do_op(f, a, b, model(f, a, b), $sformatf("rnd%0d_f%0d", i, f), 1'($urandom_range(0, 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller for the RV32M multiply/divide operations, sitting in the execute stage beside the single-cycle ALU. The decode path hands it an M-extension op (funct7 = 0000001, funct3 selects the op) plus operands. It sequences an iterative shift-add multiplier or restoring divider over XLEN cycles. While busy it holds the pipeline stalled, then returns one registered result with a single-cycle valid pulse.

Parameters:
XLEN, 32, operand/result width; also the iteration count.
CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  execute stage presents an M-extension op this cycle
in_ready  out  1  block can accept; 1 only in IDLE
funct3  in  3  op select (encoding in Behaviour)
op_a  in  XLEN  rs1 value (multiplicand / dividend)
op_b  in  XLEN  rs2 value (multiplier / divisor)
kill  in  1  pipeline flush; aborts any op in flight
busy  out  1  1 in MUL, DIV or DONE; used as execute-stage stall
out_valid  out  1  one-cycle pulse, result valid
result  out  XLEN  registered result; held until the next accept

Behaviour:
- Reset: state=IDLE, in_ready=1, busy=0, out_valid=0, result=0, counter=0, all internal registers 0.
- funct3 decode: 000 MUL (low XLEN), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Accept: occurs when in_valid && in_ready && !kill. On accept, latch:
  - funct3;
  - |op_a| and |op_b| (magnitude only if that operand is signed for the op);
  - negate-result flag:
    - MUL*: sign_a XOR sign_b, over the signed operands only;
    - DIV: sign_a XOR sign_b;
    - REM: sign_a.
- State transitions:
  - IDLE → MUL on accept with funct3[2]=0.
  - IDLE → DIV on accept with funct3[2]=1 and op_b≠0.
  - IDLE → DONE on accept with funct3[2]=1 and op_b=0 (divide-by-zero bypass).
  - MUL → DONE after XLEN iterations: 2·XLEN product register, one shift-add per cycle, counter counts 0..XLEN-1.
  - DIV → DONE after XLEN iterations: restoring divide, one quotient bit per cycle, remainder register XLEN+1 bits.
  - DONE → IDLE unconditionally after one cycle.
- Result: written on entry to DONE. Apply two's-complement negation if the flag is set, then select:
  - low product half for MUL;
  - high product half for MULH, MULHSU, MULHU;
  - quotient for DIV/DIVU;
  - remainder for REM/REMU.
  out_valid=1 exactly while in DONE.
- Latency: accepted in cycle N → out_valid in cycle N+XLEN+1 (33 for XLEN=32). Divide-by-zero → out_valid in cycle N+1.
- Divide-by-zero: quotient = all ones (DIV and DIVU), remainder = op_a unchanged. The negate flag is ignored.
- Signed overflow: DIV with op_a=-2^(XLEN-1), op_b=-1 gives quotient=op_a, remainder=0. This must fall out of the magnitude algorithm with no special case.
- kill: takes priority over everything except reset.
  - In MUL, DIV or DONE: next state is IDLE, out_valid forced 0 that cycle, result unchanged.
  - In IDLE: suppresses the accept.
- reset asserted mid-operation: returns to the reset values on the next edge, regardless of kill or in_valid.
- in_valid while busy: ignored. The stall guarantees the op is re-presented until accepted.

Decomposition:
- Package common: add enum muldiv_op_t (MD_MUL … MD_REMU, values equal to funct3) and enum md_state_t (MD_IDLE, MD_MUL, MD_DIV, MD_DONE).
- Sub-module muldiv_sign_prep (combinational): takes funct3, op_a, op_b and produces the two magnitudes plus the negate flag. It is reused for accept-time latching.
- FSM, counter and datapath registers stay in muldiv_sequencer.

Test Plan:
- MUL 7 × -3 (0xFFFFFFFD), accepted cycle 0 → out_valid=1 only in cycle 33, result=0xFFFFFFEB; in_ready=1 in cycle 34.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD. REM -7 % 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 % 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 % 0 → 5, each with out_valid in cycle 1 after accept. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same pair → 0.
- Start MUL, assert kill in cycle 10 → no out_valid ever, busy=0 and in_ready=1 in cycle 11, result keeps its previous value. Repeat with reset in cycle 10 → result=0.
- kill and in_valid together in IDLE → no accept, busy stays 0. in_valid held high during a DIV → exactly one out_valid pulse.
